// File: rtl/seg7_pkg.sv
// seg7_pkg: glyphs, blank/dash codes, converter states and double-dabble helper
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000, G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000, G9 = 7'b0010000;
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return G0;
      4'd1: return G1;
      4'd2: return G2;
      4'd3: return G3;
      4'd4: return G4;
      4'd5: return G5;
      4'd6: return G6;
      4'd7: return G7;
      4'd8: return G8;
      4'd9: return G9;
      default: return BLANK;
    endcase
  endfunction
  function automatic logic [19:0] dd_adj(input logic [19:0] b);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) r[4*i+:4] = b[4*i+:4] >= 4'd5 ? b[4*i+:4] + 4'd3 : b[4*i+:4];
    return r;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 16-bit binary to 5-digit BCD, one double-dabble step per SHIFT cycle
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);
  state_t state;
  logic [15:0] sr;
  logic [3:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      bcd <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy <= 1'b1;
        end
        LOAD: begin
          sr <= bin;
          bcd <= '0;
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, sr} <= {dd_adj(bcd), sr} << 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
      endcase
endmodule

// File: rtl/seg7_result_display.sv
// seg7_result_display: captures divider results, converts to BCD and scans a 4-digit display
module seg7_result_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit LZB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] quotient,
  input  logic [15:0] remainder,
  input  logic        show_rem,
  output logic        busy,
  output logic        ovf,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [15:0] quo_h, rem_h;
  logic last_sr, pending, cdone, req, start;
  logic [19:0] bcd;
  logic [6:0] disp [4];
  logic [6:0] nxt [4];
  logic [CW-1:0] scnt;
  logic [1:0] idx;
  bin2bcd_seq u_conv (
    .clk(clk), .rst(rst), .start(start),
    .bin(last_sr ? rem_h : quo_h),
    .busy(busy), .done(cdone), .bcd(bcd)
  );
  always_comb begin
    req = valid_in | (show_rem != last_sr);
    start = !busy && !cdone && (req || pending);
    for (int k = 0; k < 4; k++)
      nxt[k] = |bcd[19:16] ? DASH :
               (LZB && k > 0 && (bcd[15:0] >> (4*k)) == 16'd0) ? BLANK : glyph(bcd[4*k+:4]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      quo_h <= '0;
      rem_h <= '0;
      last_sr <= 1'b0;
      pending <= 1'b0;
      ovf <= 1'b0;
      for (int k = 0; k < 4; k++) disp[k] <= BLANK;
      scnt <= '0;
      idx <= '0;
      an <= 4'b1110;
      seg <= BLANK;
    end else begin
      if (valid_in) begin
        quo_h <= quotient;
        rem_h <= remainder;
      end
      if (start) last_sr <= show_rem;
      // operands are sampled in LOAD, so a request coinciding with start is already covered
      pending <= start ? 1'b0 : pending | req;
      if (cdone) begin
        ovf <= |bcd[19:16];
        for (int k = 0; k < 4; k++) disp[k] <= nxt[k];
      end
      scnt <= scnt == CW'(SCAN_DIV - 1) ? '0 : scnt + 1'b1;
      if (scnt == CW'(SCAN_DIV - 1)) idx <= idx + 2'd1;
      an <= ~(4'b0001 << idx);
      seg <= disp[idx];
    end
endmodule

// File: doc/seg7_result_display.md
SEG7_RESULT_DISPLAY -- requirements
Module: seg7_result_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot (1 ms at 50 MHz).
REQ-002 Parameter LZB, default 1: 1 blanks leading zeros, 0 shows all four digits.
REQ-003 clk  input  1  system clock, 50 MHz; the block has one clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 valid_in  input  1  single-cycle pulse from the upstream sequential divider's done; quotient/remainder valid in that cycle.
REQ-006 quotient  input  16  unsigned divider quotient.
REQ-007 remainder  input  16  unsigned divider remainder.
REQ-008 show_rem  input  1  0 displays quotient, 1 displays remainder; level, already synchronised.
REQ-009 busy  output  1  high while a binary-to-BCD conversion runs.
REQ-010 ovf  output  1  high when the displayed value exceeds 9999.
REQ-011 seg  output  7  active-low segments {g,f,e,d,c,b,a}, common anode.
REQ-012 an  output  4  active-low digit enables; an[0] is the least significant digit.

Function
REQ-013 On valid_in, the block SHALL capture quotient and remainder into hold registers; captures are not gated by busy.
REQ-014 FSM states SHALL be IDLE, LOAD, SHIFT, DONE.
- IDLE->LOAD on a conversion request.
- LOAD->SHIFT after 1 cycle.
- SHIFT lasts exactly 16 cycles, then goes to DONE.
- DONE->IDLE after 1 cycle.
REQ-015 A conversion request SHALL occur on valid_in, or when show_rem differs from the value used by the last conversion.
REQ-016 The conversion SHALL use double-dabble: per SHIFT cycle, add 3 to each BCD nibble >=5, then shift left one bit.
REQ-017 Latency SHALL be 18 cycles from the request cycle to the display register update in the DONE cycle; busy is high in LOAD and SHIFT only.
REQ-018 A request arriving while not IDLE SHALL be held as one pending flag and serviced on return to IDLE; the latest hold registers and show_rem are used.
REQ-019 When valid_in and a show_rem change occur in the same cycle, the block SHALL produce one conversion, using the new operands and the new show_rem.
REQ-020 For values >9999, DONE SHALL set ovf=1 and load the display with four dashes (seg=7'b0111111); otherwise ovf=0.
REQ-021 With LZB=1, leading zero digits SHALL be blanked (seg=7'b1111111); digit 0 is never blanked, so value 0 shows "0".
REQ-022 A scan counter SHALL wrap at SCAN_DIV-1 and advance the digit index 0->1->2->3->0.
- Exactly one an bit is low at any time.
- seg is registered together with an, so there is no glitch between them.
REQ-023 Glyphs, active-low {g..a}:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

Reset
REQ-024 Reset SHALL force: FSM=IDLE, pending=0, busy=0, ovf=0, hold registers=0, scan counter=0, digit index=0, an=4'b1110, display register=all blank, seg=7'b1111111.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no display update.
- After release the block waits for a new request.
- The show_rem value used by the last conversion resets to 0.

Structure
REQ-026 A shared package/include seg7_pkg SHALL hold the glyph constants, the BLANK and DASH constants, and the FSM state encodings.
REQ-027 The sequential converter SHALL be the sub-module bin2bcd_seq.
- Ports: clk, rst, start, bin[15:0], busy, done, bcd[19:0].
- The top level holds capture logic, ovf detection, blanking and scan.

Verification
REQ-028 quotient=1234, valid_in pulse -> busy high 17 cycles; after 18 cycles, scan shows an=1110 seg 0011001, 1101 0110000, 1011 0100100, 0111 1111001; ovf=0.
REQ-029 quotient=7, LZB=1 -> digit 0 shows 1111000; digits 1-3 show 1111111. quotient=0 -> digit 0 shows 1000000.
REQ-030 quotient=12345 -> ovf=1, all four digits show 0111111. Then remainder=9999 with show_rem 0->1 -> ovf=0, all digits show 0010000.
REQ-031 A second valid_in during SHIFT with quotient=42 -> exactly one extra conversion follows; the final display is "42".
REQ-032 rst pulsed at SHIFT cycle 8 -> busy=0 and display blank immediately; no update until the next valid_in.
REQ-033 Scan timing with SCAN_DIV=4 -> an rotates every 4 cycles; exactly one an bit is low in every cycle.
